// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result streaming path.
// Geometry, default widths, FSM states and width helpers.
package fft_pkg;

    localparam int N          = 4;
    localparam int LANES      = N;
    localparam int NSAMP      = N * N;
    localparam int DATA_W_DEF = 16;

    localparam int SAMPLE_W_DEF = 2 * DATA_W_DEF;
    localparam int FLAT_W_DEF   = NSAMP * SAMPLE_W_DEF;
    localparam int BEAT_W_DEF   = LANES * SAMPLE_W_DEF;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int sample_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int flat_w(input int dw);
        return NSAMP * 2 * dw;
    endfunction

    function automatic int beat_w(input int dw);
        return LANES * 2 * dw;
    endfunction

endpackage

// File: rtl/fft_row_select.sv
// Picks one row (or one column when transposed) of the held frame.
// Purely combinational; lane j of the beat comes from one buffer sample.
module fft_row_select
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [flat_w(DATA_W)-1:0] frame,
    input  logic [1:0]                idx,
    input  logic                      transpose,
    output logic [beat_w(DATA_W)-1:0] lanes
);

    localparam int SW = sample_w(DATA_W);

    // Row-major picks (r=idx, c=j); column-major picks (r=j, c=idx).
    always_comb begin
        lanes = '0;
        for (int j = 0; j < LANES; j++) begin
            int k;
            if (transpose) begin
                k = j * N + int'(idx);
            end else begin
                k = int'(idx) * N + j;
            end
            lanes[SW*j +: SW] = frame[SW*k +: SW];
        end
    end

endmodule

// File: rtl/fft_result_streamer.sv
// Captures a finished 4x4 complex FFT frame and streams it as four
// 4-lane beats over valid/ready, row-major or column-major per frame.
module fft_result_streamer
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fft_done,
    input  logic                  transpose,
    input  logic [32*DATA_W-1:0]  result_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*DATA_W-1:0]   out_data,
    output logic [1:0]            out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          idx_q;
    logic [32*DATA_W-1:0] frame_q;
    logic                tpose_q;
    logic                frame_done_q;
    logic                overflow_q;

    logic                hs;
    logic                last_hs;
    logic                capture;
    logic                drop;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake decode and capture/drop decisions.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        hs        = 1'b0;
        last_hs   = 1'b0;
        capture   = 1'b0;
        drop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fft_done) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                hs        = out_ready;
                if (out_ready && idx_q == 2'd3) begin
                    last_hs = 1'b1;
                    if (fft_done) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fft_done) begin
                    drop = 1'b1;
                end
            end
        endcase
    end

    // Frame buffer, beat counter and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q      <= '0;
            tpose_q      <= 1'b0;
            idx_q        <= 2'd0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (capture) begin
                frame_q <= result_flat;
                tpose_q <= transpose;
                idx_q   <= 2'd0;
            end else if (hs) begin
                idx_q <= idx_q + 2'd1;
            end
            frame_done_q <= last_hs;
            overflow_q   <= overflow_q | drop;
        end
    end

    fft_row_select #(
        .DATA_W(DATA_W)
    ) u_row_select (
        .frame    (frame_q),
        .idx      (idx_q),
        .transpose(tpose_q),
        .lanes    (out_data)
    );

    assign out_index  = idx_q;
    assign out_last   = (state_q == STREAM) && (idx_q == 2'd3);
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/fft_result_streamer.md
# fft_result_streamer

Output-side counterpart of the 4x4 2D FFT load sequencer. The sequencer feeds four input rows into the datapath and pulses completion. This block captures the finished 16-sample complex result in one cycle and transmits it downstream as four 4-sample beats over a valid/ready handshake. It sits between the FFT datapath's result bus and the consumer, in row-major or transposed (column-major) order selected per frame.

## Interface
Parameters:
- DATA_W, 16, width of each real and each imaginary component (signed, two's complement, passed through unmodified)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- fft_done  in  1  capture strobe from datapath/sequencer; result_flat valid in this cycle
- transpose  in  1  sampled with fft_done; 1 = column-major output for that frame
- result_flat  in  32*DATA_W  sample k=4r+c at bits [2*DATA_W*k +: 2*DATA_W]; real in the lower DATA_W bits, imag in the upper
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  8*DATA_W  lane j at [2*DATA_W*j +: 2*DATA_W], same re/im packing
- out_index  out  2  beat number 0..3 (row or column index)
- out_last  out  1  high with beat 3
- busy  out  1  frame held (state != IDLE)
- frame_done  out  1  one-cycle pulse after beat 3 accepted
- overflow  out  1  sticky; frame dropped because block was busy

## Operation
- States: IDLE, STREAM. Beat counter idx[1:0]. Frame buffer: 16 complex registers plus latched transpose bit.
- IDLE + fft_done: load buffer from result_flat, latch transpose, idx=0, go to STREAM.
- STREAM: out_valid=1. Handshake = out_valid & out_ready.
  - On handshake with idx<3: idx+1.
  - On handshake with idx=3: go to IDLE and pulse frame_done the next cycle.
- Normal order: beat i lane j = sample (r=i, c=j).
- Transposed order: beat i lane j = sample (r=j, c=i).
- out_data, out_index and out_last are functions of registers only (buffer, idx, latched transpose). No combinational path from inputs to outputs.
- Back-to-back frames: fft_done coincident with the beat-3 handshake is accepted. The buffer reloads, idx=0, state stays STREAM, and frame_done still pulses the next cycle.
- fft_done in STREAM without a beat-3 handshake: the new frame is dropped, overflow sets, and the current frame continues unchanged.
- overflow clears only on reset.
- Backpressure: while out_valid & !out_ready, out_data, out_index and out_last hold stable indefinitely.

## Timing
- Reset values: out_valid=0, out_data=0 (buffer cleared), out_index=0, out_last=0, busy=0, frame_done=0, overflow=0, state IDLE.
- Latency: fft_done in cycle T means out_valid=1 with beat 0 in T+1.
- With out_ready held high, beats 0..3 are presented in T+1..T+4, frame_done=1 in T+5, busy falls in T+5.
- Throughput: one beat per cycle. Sustained frames at one per 4 cycles using the coincident-capture rule.
- busy is high from T+1 through the cycle of the final handshake.
- Reset mid-frame: the frame is discarded and all outputs return to reset values asynchronously. No frame_done is produced.
- out_ready is ignored while out_valid=0.

## Structure
- Shared package fft_pkg holds:
  - N=4 and lane count
  - DATA_W default
  - state encodings IDLE/STREAM
  - localparams for sample width (2*DATA_W) and the flat-bus widths
- One sub-module, fft_row_select. It is purely combinational: it takes the buffer, idx and transpose and produces the 4-lane out_data. It is instantiated once.

## Test plan
- Basic frame: sample k re=k, im=16+k, transpose=0, out_ready=1.
  - Beat i lanes carry re=4i..4i+3, out_last on beat 3.
  - frame_done pulses exactly at T+5.
- Transposed frame: same data, transpose=1.
  - Beat i lane j has re=4j+i. For example, beat 1 carries re=1,5,9,13.
- Backpressure: out_ready=0 for 5 cycles during beat 2.
  - out_data/out_index hold at beat 2 values.
  - No beat is skipped or duplicated.
- Back-to-back: second fft_done (re=100+k) coincident with the first frame's beat-3 handshake.
  - The second frame's beat 0 follows with no gap.
  - frame_done pulses once per frame.
  - overflow stays 0.
- Overflow: fft_done during beat 1 of a frame.
  - The current frame completes with its original data.
  - overflow=1 and remains 1 after a later valid frame.
- Reset mid-frame: assert reset during beat 2.
  - All outputs go to 0 immediately.
  - A following fft_done streams the new frame from beat 0.
